axicb_mst_wr_arbiter: RTL and testbench

Write-path arbiter placed in front of one slave port of the crossbar. It shares that slave's AW/W/B channels between MST_NB master-side switches. AW requests are granted round-robin. The granted master's index is queued so W beats follow the same order as AW. B responses are routed back to the owning master by decoding the ID prefix.

---
 rtl/axicb_mst_wr_arbiter_if.sv | 28 ++
 rtl/axicb_mst_wr_arbiter.sv | 162 ++++++++++++++++
 tb/tb_axicb_mst_wr_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axicb_mst_wr_arbiter_if.sv
// AXI write-channel bundle (AW/W/B) for NB ports; payloads are packed per port.
interface axicb_mst_wr_arbiter_if #(
    parameter int unsigned NB     = 1,
    parameter int unsigned AWCH_W = 8,
    parameter int unsigned WCH_W  = 8,
    parameter int unsigned BCH_W  = 8
);
    logic [NB-1:0]        awvalid;
    logic [NB-1:0]        awready;
    logic [NB*AWCH_W-1:0] awch;
    logic [NB-1:0]        wvalid;
    logic [NB-1:0]        wready;
    logic [NB-1:0]        wlast;
    logic [NB*WCH_W-1:0]  wch;
    logic [NB-1:0]        bvalid;
    logic [NB-1:0]        bready;
    logic [NB*BCH_W-1:0]  bch;

    modport master (
        output awvalid, awch, wvalid, wlast, wch, bready,
        input  awready, wready, bvalid, bch
    );

    modport slave (
        input  awvalid, awch, wvalid, wlast, wch, bready,
        output awready, wready, bvalid, bch
    );
endinterface

// File: rtl/axicb_mst_wr_arbiter.sv
// Shares one slave's AW/W/B channels between MST_NB masters: round-robin AW,
// W ordered by an AW-grant FIFO, B routed back by ID prefix.
module axicb_mst_wr_arbiter #(
    parameter int unsigned         MST_NB        = 4,
    parameter int unsigned         AXI_ADDR_W    = 8,
    parameter int unsigned         AXI_ID_W      = 8,
    parameter int unsigned         AWCH_W        = 8,
    parameter int unsigned         WCH_W         = 8,
    parameter int unsigned         BCH_W         = 8,
    parameter int unsigned         ORDER_DEPTH_W = 3,
    parameter logic [AXI_ID_W-1:0] MST0_ID_MASK  = 'h10,
    parameter logic [AXI_ID_W-1:0] MST1_ID_MASK  = 'h20,
    parameter logic [AXI_ID_W-1:0] MST2_ID_MASK  = 'h40,
    parameter logic [AXI_ID_W-1:0] MST3_ID_MASK  = 'h80
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   srst,
    axicb_mst_wr_arbiter_if.slave  mst,
    axicb_mst_wr_arbiter_if.master slv
);
    localparam int unsigned IDX_W = (MST_NB > 1) ? $clog2(MST_NB) : 1;
    localparam int unsigned DEPTH = 1 << ORDER_DEPTH_W;
    localparam logic [3:0][AXI_ID_W-1:0] ID_MASK =
        {MST3_ID_MASK, MST2_ID_MASK, MST1_ID_MASK, MST0_ID_MASK};

    typedef enum logic {ARB_OPEN, ARB_HELD} arb_state_t;

    arb_state_t state, state_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt, held_idx, held_nxt, rr_idx, grant;
    logic rr_hit, run, any_req, aw_valid, aw_hs;

    logic [MST_NB-1:0]      order_mem [DEPTH];
    logic [ORDER_DEPTH_W:0] wr_ptr, rd_ptr;
    logic [MST_NB-1:0]      head, push_oh;
    logic                   fifo_full, fifo_empty, w_valid, w_pull;
    logic                   sel_wvalid, sel_wlast;
    logic [WCH_W-1:0]       sel_wch;

    logic [AXI_ID_W-1:0] bid;
    logic [MST_NB-1:0]   bsel;
    logic                bmatch;

    // Either reset source forces every output low without waiting for a clock.
    assign run = aresetn & ~srst;

    always_comb begin
        rr_idx = ptr;
        rr_hit = 1'b0;
        for (int unsigned k = 0; k < MST_NB; k++) begin
            if (!rr_hit && mst.awvalid[(32'(ptr) + k) % MST_NB]) begin
                rr_idx = IDX_W'((32'(ptr) + k) % MST_NB);
                rr_hit = 1'b1;
            end
        end
    end

    assign grant    = (state == ARB_HELD) ? held_idx : rr_idx;
    assign any_req  = |mst.awvalid;
    assign aw_valid = run & any_req & ~fifo_full;
    assign aw_hs    = aw_valid & slv.awready[0];

    assign slv.awvalid = aw_valid;
    assign slv.awch    = run ? mst.awch[grant*AWCH_W +: AWCH_W] : '0;

    always_comb begin
        mst.awready        = '0;
        mst.awready[grant] = aw_hs;
        push_oh            = '0;
        push_oh[grant]     = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        held_nxt  = held_idx;
        if (aw_hs) begin
            state_nxt = ARB_OPEN;
            ptr_nxt   = (grant == IDX_W'(MST_NB - 1)) ? '0 : grant + IDX_W'(1);
        end else if (aw_valid) begin
            state_nxt = ARB_HELD;
            held_nxt  = grant;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= ARB_OPEN;
            ptr      <= '0;
            held_idx <= '0;
        end else if (srst) begin
            state    <= ARB_OPEN;
            ptr      <= '0;
            held_idx <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            held_idx <= held_nxt;
        end
    end

    // Pointers carry one extra wrap bit to tell full from empty.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[ORDER_DEPTH_W] != rd_ptr[ORDER_DEPTH_W]) &&
                        (wr_ptr[ORDER_DEPTH_W-1:0] == rd_ptr[ORDER_DEPTH_W-1:0]);
    assign head       = order_mem[rd_ptr[ORDER_DEPTH_W-1:0]];

    always_ff @(posedge aclk) begin
        if (aw_hs) order_mem[wr_ptr[ORDER_DEPTH_W-1:0]] <= push_oh;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (srst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (aw_hs)  wr_ptr <= wr_ptr + 1'b1;
            if (w_pull) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_comb begin
        sel_wvalid = 1'b0;
        sel_wlast  = 1'b0;
        sel_wch    = '0;
        for (int unsigned n = 0; n < MST_NB; n++) begin
            if (head[n]) begin
                sel_wvalid = mst.wvalid[n];
                sel_wlast  = mst.wlast[n];
                sel_wch    = mst.wch[n*WCH_W +: WCH_W];
            end
        end
    end

    assign w_valid     = run & ~fifo_empty & sel_wvalid;
    assign w_pull      = w_valid & slv.wready[0] & sel_wlast;
    assign slv.wvalid  = w_valid;
    assign slv.wlast   = run & sel_wlast;
    assign slv.wch     = run ? sel_wch : '0;
    assign mst.wready  = (run & ~fifo_empty & slv.wready[0]) ? head : '0;

    assign bid = slv.bch[AXI_ID_W-1:0];

    always_comb begin
        bsel   = '0;
        bmatch = 1'b0;
        for (int unsigned n = 0; n < MST_NB; n++) begin
            if (!bmatch && ((bid & ID_MASK[n]) == ID_MASK[n])) begin
                bsel[n] = 1'b1;
                bmatch  = 1'b1;
            end
        end
    end

    // Unclaimed IDs are acknowledged and dropped so the slave never stalls.
    assign mst.bvalid = (run & slv.bvalid[0]) ? bsel : '0;
    assign slv.bready = run & (bmatch ? |(bsel & mst.bready) : 1'b1);
    assign mst.bch    = run ? {MST_NB{slv.bch}} : '0;
endmodule

// File: tb/tb_axicb_mst_wr_arbiter.sv
// Self-checking bench for axicb_mst_wr_arbiter: directed scenarios plus random traffic vs a queue model.
module tb_axicb_mst_wr_arbiter;
    localparam int NB    = 4;
    localparam int AWW   = 8;
    localparam int WW    = 8;
    localparam int BW    = 8;
    localparam int DEPTH = 8;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    logic srst    = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 aclk = ~aclk;

    axicb_mst_wr_arbiter_if #(.NB(NB), .AWCH_W(AWW), .WCH_W(WW), .BCH_W(BW)) mst_if ();
    axicb_mst_wr_arbiter_if #(.NB(1),  .AWCH_W(AWW), .WCH_W(WW), .BCH_W(BW)) slv_if ();

    axicb_mst_wr_arbiter #(
        .MST_NB(NB), .AXI_ADDR_W(8), .AXI_ID_W(8), .AWCH_W(AWW), .WCH_W(WW), .BCH_W(BW),
        .ORDER_DEPTH_W(3), .MST0_ID_MASK(8'h10), .MST1_ID_MASK(8'h20),
        .MST2_ID_MASK(8'h40), .MST3_ID_MASK(8'h80)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .srst(srst), .mst(mst_if), .slv(slv_if)
    );

    // Reference model: pointer, lock and a queue of granted master indices.
    int m_ptr;
    int m_q[$];
    bit m_lock;
    int m_lidx;
    int mask [NB] = '{8'h10, 8'h20, 8'h40, 8'h80};

    int              e_grant;
    logic            e_awvalid, e_wvalid, e_wlast, e_bready;
    logic [NB-1:0]   e_awready, e_wready, e_bvalid;
    logic [AWW-1:0]  e_awch;
    logic [WW-1:0]   e_wch;

    task automatic model_reset();
        m_ptr = 0; m_q.delete(); m_lock = 0; m_lidx = 0;
    endtask

    task automatic model_eval();
        int g, h, sel;
        logic [7:0] bid;
        g = -1;
        if (m_lock) g = m_lidx;
        else for (int k = 0; k < NB; k++)
            if (g < 0 && mst_if.awvalid[(m_ptr + k) % NB]) g = (m_ptr + k) % NB;
        e_grant   = g;
        e_awvalid = (mst_if.awvalid != 0) && (m_q.size() < DEPTH);
        e_awch    = (g >= 0) ? mst_if.awch[g*AWW +: AWW] : '0;
        e_awready = '0;
        if (e_awvalid && slv_if.awready[0]) e_awready[g] = 1'b1;
        e_wvalid = 1'b0; e_wlast = 1'b0; e_wch = '0; e_wready = '0;
        if (m_q.size() > 0) begin
            h = m_q[0];
            e_wvalid = mst_if.wvalid[h];
            e_wlast  = mst_if.wlast[h];
            e_wch    = mst_if.wch[h*WW +: WW];
            if (slv_if.wready[0]) e_wready[h] = 1'b1;
        end
        bid = slv_if.bch;
        sel = -1;
        for (int n = 0; n < NB; n++)
            if (sel < 0 && (int'(bid) & mask[n]) == mask[n]) sel = n;
        e_bvalid = '0;
        if (sel >= 0 && slv_if.bvalid[0]) e_bvalid[sel] = 1'b1;
        e_bready = (sel < 0) ? 1'b1 : mst_if.bready[sel];
    endtask

    task automatic model_step();
        bit push, pull;
        push = e_awvalid && slv_if.awready[0];
        pull = e_wvalid && slv_if.wready[0] && e_wlast;
        if (e_awvalid && !slv_if.awready[0]) begin m_lock = 1; m_lidx = e_grant; end
        if (push) begin m_lock = 0; m_ptr = (e_grant + 1) % NB; end
        if (pull) void'(m_q.pop_front());
        if (push) m_q.push_back(e_grant);
    endtask

    task automatic drive_idle();
        mst_if.awvalid = '0; mst_if.awch = '0; mst_if.wvalid = '0; mst_if.wlast = '0;
        mst_if.wch = '0; mst_if.bready = '0;
        slv_if.awready = '0; slv_if.wready = '0; slv_if.bvalid = '0; slv_if.bch = '0;
    endtask

    task automatic apply_reset();
        drive_idle();
        aresetn = 1'b0;
        @(posedge aclk); @(posedge aclk); #1;
        aresetn = 1'b1;
        model_reset();
    endtask

    task automatic settle();
        @(negedge aclk);
        model_eval();
    endtask

    task automatic adv();
        model_step();
        @(posedge aclk); #1;
    endtask

    task automatic test_reset();
        drive_idle();
        aresetn = 1'b0;
        mst_if.awvalid = '1; mst_if.awch = 32'($urandom); mst_if.wvalid = '1; mst_if.wlast = '1;
        mst_if.bready = '1; slv_if.awready = 1'b1; slv_if.wready = 1'b1;
        slv_if.bvalid = 1'b1; slv_if.bch = 8'h10;
        @(negedge aclk);
        n_checks++; if ({slv_if.awvalid, slv_if.wvalid, slv_if.bready} !== 3'b000) begin
            n_fail++; $display("FAIL reset_slv_ctrl got=%b exp=000", {slv_if.awvalid, slv_if.wvalid, slv_if.bready}); end
        n_checks++; if ({mst_if.awready, mst_if.wready, mst_if.bvalid} !== 12'h000) begin
            n_fail++; $display("FAIL reset_mst_ctrl got=%h exp=000", {mst_if.awready, mst_if.wready, mst_if.bvalid}); end
        n_checks++; if ({mst_if.bch, slv_if.awch} !== '0) begin
            n_fail++; $display("FAIL reset_payload got=%h exp=0", {mst_if.bch, slv_if.awch}); end
        @(posedge aclk); #1;
        aresetn = 1'b1; model_reset(); slv_if.bvalid = 1'b0;
        settle();
        n_checks++; if (mst_if.awready !== 4'b0001) begin
            n_fail++; $display("FAIL reset_rr_ptr got=%b exp=0001", mst_if.awready); end
        n_checks++; if (slv_if.wvalid !== 1'b0) begin
            n_fail++; $display("FAIL reset_fifo_empty got=%b exp=0", slv_if.wvalid); end
        adv();
        srst = 1'b1;
        settle();
        n_checks++; if ({slv_if.awvalid, slv_if.wvalid, mst_if.awready} !== 6'b0) begin
            n_fail++; $display("FAIL srst_outputs got=%b exp=000000", {slv_if.awvalid, slv_if.wvalid, mst_if.awready}); end
        @(posedge aclk); #1;
        srst = 1'b0; model_reset();
        settle();
        n_checks++; if (slv_if.wvalid !== 1'b0) begin
            n_fail++; $display("FAIL srst_fifo_empty got=%b exp=0", slv_if.wvalid); end
        n_checks++; if (mst_if.awready !== 4'b0001) begin
            n_fail++; $display("FAIL srst_rr_ptr got=%b exp=0001", mst_if.awready); end
    endtask

    task automatic test_rr_grant();
        logic [3:0] req [6] = '{4'b0101, 4'b0100, 4'b0001, 4'b0111, 4'b0101, 4'b0001};
        logic [3:0] gnt [6] = '{4'b0001, 4'b0100, 4'b0001, 4'b0010, 4'b0100, 4'b0001};
        apply_reset();
        slv_if.awready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            mst_if.awvalid = req[i];
            mst_if.awch    = 32'($urandom);
            settle();
            n_checks++; if (mst_if.awready !== gnt[i]) begin
                n_fail++; $display("FAIL rr_grant step=%0d got=%b exp=%b", i, mst_if.awready, gnt[i]); end
            n_checks++; if (slv_if.awch !== e_awch) begin
                n_fail++; $display("FAIL rr_awch step=%0d got=%h exp=%h", i, slv_if.awch, e_awch); end
            adv();
        end
    endtask

    task automatic test_lock();
        logic [7:0] p0, p1;
        apply_reset();
        p0 = 8'($urandom); p1 = 8'($urandom);
        mst_if.awch = {16'h0, p1, p0};
        mst_if.awvalid = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) mst_if.awvalid[0] = 1'b1;
            settle();
            n_checks++; if (slv_if.awvalid !== 1'b1 || slv_if.awch !== p1) begin
                n_fail++; $display("FAIL lock_hold cyc=%0d got=%b/%h exp=1/%h", c, slv_if.awvalid, slv_if.awch, p1); end
            adv();
        end
        slv_if.awready = 1'b1;
        settle();
        n_checks++; if (mst_if.awready !== 4'b0010 || slv_if.awch !== p1) begin
            n_fail++; $display("FAIL lock_release got=%b/%h exp=0010/%h", mst_if.awready, slv_if.awch, p1); end
        adv();
        mst_if.awvalid[1] = 1'b0;
        settle();
        n_checks++; if (mst_if.awready !== 4'b0001 || slv_if.awch !== p0) begin
            n_fail++; $display("FAIL lock_next got=%b/%h exp=0001/%h", mst_if.awready, slv_if.awch, p0); end
        adv();
    endtask

    task automatic test_w_order();
        logic [7:0] b0 [4];
        logic [7:0] b3 [4];
        for (int k = 0; k < 4; k++) begin b0[k] = 8'($urandom); b3[k] = 8'($urandom); end
        apply_reset();
        slv_if.awready = 1'b1; slv_if.wready = 1'b1;
        mst_if.awvalid = 4'b1000; mst_if.awch = 32'($urandom);
        settle(); adv();
        mst_if.awvalid = 4'b0001; mst_if.wvalid = 4'b0001; mst_if.wch[7:0] = b0[0];
        for (int c = 0; c < 2; c++) begin
            settle();
            n_checks++; if (slv_if.wvalid !== 1'b0 || mst_if.wready !== 4'b1000) begin
                n_fail++; $display("FAIL w_early_hold cyc=%0d got=%b/%b exp=0/1000", c, slv_if.wvalid, mst_if.wready); end
            adv();
            mst_if.awvalid = '0;
        end
        for (int k = 0; k < 4; k++) begin
            mst_if.wvalid[3] = 1'b1; mst_if.wch[31:24] = b3[k]; mst_if.wlast[3] = (k == 3);
            settle();
            n_checks++; if (slv_if.wvalid !== 1'b1 || slv_if.wch !== b3[k] || slv_if.wlast !== (k == 3)
                            || mst_if.wready !== 4'b1000) begin
                n_fail++; $display("FAIL w_m3_beat k=%0d got=%b/%h/%b exp=1/%h/1000", k, slv_if.wvalid, slv_if.wch, mst_if.wready, b3[k]); end
            adv();
        end
        mst_if.wvalid[3] = 1'b0; mst_if.wlast[3] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mst_if.wch[7:0] = b0[k]; mst_if.wlast[0] = (k == 3);
            settle();
            n_checks++; if (slv_if.wvalid !== 1'b1 || slv_if.wch !== b0[k] || mst_if.wready !== 4'b0001) begin
                n_fail++; $display("FAIL w_m0_beat k=%0d got=%b/%h/%b exp=1/%h/0001", k, slv_if.wvalid, slv_if.wch, mst_if.wready, b0[k]); end
            adv();
        end
        mst_if.wlast[0] = 1'b0;
        settle();
        n_checks++; if (slv_if.wvalid !== 1'b0) begin
            n_fail++; $display("FAIL w_drained got=%b exp=0", slv_if.wvalid); end
        adv();
    endtask

    task automatic test_fifo_full();
        int m, first, m9;
        apply_reset();
        slv_if.awready = 1'b1; slv_if.wready = 1'b1;
        first = 0;
        for (int i = 0; i < DEPTH; i++) begin
            m = $urandom_range(0, NB - 1);
            if (i == 0) first = m;
            mst_if.awvalid = 4'(1) << m; mst_if.awch = 32'($urandom);
            settle();
            n_checks++; if (mst_if.awready !== 4'(1) << m) begin
                n_fail++; $display("FAIL full_fill i=%0d got=%b exp=%b", i, mst_if.awready, 4'(1) << m); end
            adv();
        end
        m9 = $urandom_range(0, NB - 1);
        mst_if.awvalid = 4'(1) << m9;
        settle();
        n_checks++; if (slv_if.awvalid !== 1'b0 || mst_if.awready !== 4'b0) begin
            n_fail++; $display("FAIL full_block got=%b/%b exp=0/0000", slv_if.awvalid, mst_if.awready); end
        adv();
        mst_if.wvalid = 4'(1) << first; mst_if.wlast = 4'(1) << first; mst_if.wch = 32'($urandom);
        settle();
        n_checks++; if (slv_if.wvalid !== 1'b1 || slv_if.awvalid !== 1'b0) begin
            n_fail++; $display("FAIL full_pull got=%b/%b exp=1/0", slv_if.wvalid, slv_if.awvalid); end
        adv();
        mst_if.wvalid = '0; mst_if.wlast = '0;
        settle();
        n_checks++; if (slv_if.awvalid !== 1'b1 || mst_if.awready !== 4'(1) << m9) begin
            n_fail++; $display("FAIL full_freed got=%b/%b exp=1/%b", slv_if.awvalid, mst_if.awready, 4'(1) << m9); end
        adv();
    endtask

    task automatic test_b_route();
        apply_reset();
        slv_if.bvalid = 1'b1; slv_if.bch = 8'h23; mst_if.bready = 4'b1101;
        settle();
        n_checks++; if (mst_if.bvalid !== 4'b0010 || slv_if.bready !== 1'b0) begin
            n_fail++; $display("FAIL b_sel_m1 got=%b/%b exp=0010/0", mst_if.bvalid, slv_if.bready); end
        n_checks++; if (mst_if.bch !== 32'h23232323) begin
            n_fail++; $display("FAIL b_broadcast got=%h exp=23232323", mst_if.bch); end
        adv();
        mst_if.bready = 4'b0010;
        settle();
        n_checks++; if (slv_if.bready !== 1'b1) begin
            n_fail++; $display("FAIL b_ready_m1 got=%b exp=1", slv_if.bready); end
        adv();
        slv_if.bch = 8'h05; mst_if.bready = 4'b0000;
        settle();
        n_checks++; if (mst_if.bvalid !== 4'b0000 || slv_if.bready !== 1'b1) begin
            n_fail++; $display("FAIL b_drop got=%b/%b exp=0000/1", mst_if.bvalid, slv_if.bready); end
        adv();
        for (int i = 0; i < 24; i++) begin
            slv_if.bvalid = 1'($urandom); slv_if.bch = 8'($urandom); mst_if.bready = 4'($urandom);
            settle();
            n_checks++; if (mst_if.bvalid !== e_bvalid || slv_if.bready !== e_bready) begin
                n_fail++; $display("FAIL b_rand i=%0d bid=%h got=%b/%b exp=%b/%b", i, slv_if.bch, mst_if.bvalid, slv_if.bready, e_bvalid, e_bready); end
            adv();
        end
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        slv_if.awready = 1'b1; slv_if.wready = 1'b1;
        mst_if.awvalid = 4'b0001; mst_if.awch = 32'($urandom);
        settle(); adv();
        mst_if.awvalid = '0; mst_if.wvalid = 4'b0001; mst_if.wch = 32'($urandom);
        settle(); adv();
        mst_if.wch = 32'($urandom); mst_if.awvalid = 4'b0100; mst_if.bready = '1;
        slv_if.bvalid = 1'b1; slv_if.bch = 8'h40;
        settle();
        n_checks++; if (slv_if.wvalid !== 1'b1) begin
            n_fail++; $display("FAIL midrst_beat2 got=%b exp=1", slv_if.wvalid); end
        #1 aresetn = 1'b0;
        #1;
        n_checks++; if ({slv_if.awvalid, slv_if.wvalid, slv_if.bready, slv_if.wch, slv_if.awch} !== '0) begin
            n_fail++; $display("FAIL midrst_slv got=%h exp=0", {slv_if.awvalid, slv_if.wvalid, slv_if.bready, slv_if.wch, slv_if.awch}); end
        n_checks++; if ({mst_if.awready, mst_if.wready, mst_if.bvalid, mst_if.bch} !== '0) begin
            n_fail++; $display("FAIL midrst_mst got=%h exp=0", {mst_if.awready, mst_if.wready, mst_if.bvalid, mst_if.bch}); end
        @(posedge aclk); @(posedge aclk); #1;
        aresetn = 1'b1; model_reset();
        slv_if.bvalid = 1'b0; mst_if.awvalid = 4'b1111;
        settle();
        n_checks++; if (slv_if.wvalid !== 1'b0 || mst_if.awready !== 4'b0001) begin
            n_fail++; $display("FAIL midrst_after got=%b/%b exp=0/0001", slv_if.wvalid, mst_if.awready); end
        adv();
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            mst_if.awvalid = 4'($urandom) & 4'($urandom);
            mst_if.awch    = 32'($urandom);
            mst_if.wvalid  = 4'($urandom);
            mst_if.wlast   = 4'($urandom);
            mst_if.wch     = 32'($urandom);
            mst_if.bready  = 4'($urandom);
            slv_if.awready = ($urandom_range(0, 3) != 0);
            slv_if.wready  = ($urandom_range(0, 3) != 0);
            slv_if.bvalid  = 1'($urandom);
            slv_if.bch     = 8'($urandom);
            settle();
            n_checks++; if (slv_if.awvalid !== e_awvalid || mst_if.awready !== e_awready) begin
                n_fail++; $display("FAIL rand_aw cyc=%0d got=%b/%b exp=%b/%b", c, slv_if.awvalid, mst_if.awready, e_awvalid, e_awready); end
            if (e_awvalid) begin
                n_checks++; if (slv_if.awch !== e_awch) begin
                    n_fail++; $display("FAIL rand_awch cyc=%0d got=%h exp=%h", c, slv_if.awch, e_awch); end
            end
            n_checks++; if (slv_if.wvalid !== e_wvalid || mst_if.wready !== e_wready) begin
                n_fail++; $display("FAIL rand_w cyc=%0d got=%b/%b exp=%b/%b", c, slv_if.wvalid, mst_if.wready, e_wvalid, e_wready); end
            if (e_wvalid) begin
                n_checks++; if (slv_if.wch !== e_wch || slv_if.wlast !== e_wlast) begin
                    n_fail++; $display("FAIL rand_wdata cyc=%0d got=%h/%b exp=%h/%b", c, slv_if.wch, slv_if.wlast, e_wch, e_wlast); end
            end
            n_checks++; if (mst_if.bvalid !== e_bvalid || slv_if.bready !== e_bready) begin
                n_fail++; $display("FAIL rand_b cyc=%0d got=%b/%b exp=%b/%b", c, mst_if.bvalid, slv_if.bready, e_bvalid, e_bready); end
            adv();
        end
    endtask

    initial begin
        drive_idle();
        model_reset();
        test_reset();
        test_rr_grant();
        test_lock();
        test_w_order();
        test_fifo_full();
        test_b_route();
        test_reset_mid_burst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
